// File: rtl/wisc_mem_pkg.sv
// Shared types and constants for the MEM-stage data-memory slice.
//   dmem_state_t : responder FSM encoding (IDLE/WAIT/RESP)
//   WORD_W       : native data word width
//   MEM_LAT_W    : width of the access-latency counter (supports 1..15)
package wisc_mem_pkg;

  localparam int WORD_W    = 16;
  localparam int MEM_LAT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Data-memory request/response bus between the pipeline MEM stage (master)
// and the memory responder (slave).
//   req_valid/req_write/req_addr/req_wdata : request, master -> slave
//   req_ready                              : slave can accept this cycle
//   resp_valid/resp_rdata                  : one-cycle completion + load data
//   stall                                  : freeze upstream pipeline registers
interface dmem_responder_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);

  logic              req_valid;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_ready;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              stall;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, stall
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, stall
  );

endinterface

// File: rtl/dmem_responder_sp_sync_ram.sv
// Single-port synchronous RAM, one-cycle read latency.
//   clk   : clock
//   en    : access enable for this cycle
//   we    : 1 = write wdata to addr, 0 = read addr into rdata
//   addr  : word index
//   wdata : write data
//   rdata : registered read data; holds across writes and idle cycles
// A write never updates rdata, so the last load result stays visible until
// the next read.
module sp_sync_ram #(
  parameter int    DATA_W     = 16,
  parameter int    DEPTH_LOG2 = 12,
  parameter string INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [0:(1<<DEPTH_LOG2)-1];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Responder end of the MEM-stage data-memory interface.
// Accepts one load/store per transaction, models a fixed LATENCY-cycle
// access, pulses resp_valid for one cycle on completion and stalls the
// pipeline while the access is outstanding.
//   clk : clock (posedge)
//   rst : synchronous reset, active-high
//   bus : dmem_responder_if.slave (request in, ready/response/stall out)
module dmem_responder
  import wisc_mem_pkg::*;
#(
  parameter int    DATA_W     = 16,
  parameter int    ADDR_W     = 16,
  parameter int    DEPTH_LOG2 = 12,
  parameter int    LATENCY    = 4,
  parameter string INIT_FILE  = ""
) (
  input  logic                   clk,
  input  logic                   rst,
  dmem_responder_if.slave        bus
);

  generate
    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
      $fatal(1, "dmem_responder: LATENCY must be in 1..15");
    end
    if (DEPTH_LOG2 > ADDR_W) begin : g_bad_depth
      $fatal(1, "dmem_responder: DEPTH_LOG2 exceeds ADDR_W");
    end
  endgenerate

  localparam logic [MEM_LAT_W-1:0] CNT_INIT = MEM_LAT_W'(LATENCY - 1);
  localparam logic [MEM_LAT_W-1:0] CNT_ONE  = MEM_LAT_W'(1);

  dmem_state_t           state_q, state_d;
  logic [MEM_LAT_W-1:0]  cnt_q, cnt_d;

  // Request latch
  logic                  write_q;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [DATA_W-1:0]     wdata_q;

  // Set by a load response, cleared by a store response or reset; gates the
  // RAM's held read register onto resp_rdata.
  logic                  rdata_live_q;

  logic                  accept;
  logic                  go_resp;
  logic                  acc_write;
  logic [DEPTH_LOG2-1:0] acc_idx;
  logic [DATA_W-1:0]     acc_wdata;
  logic                  mem_en;
  logic [DATA_W-1:0]     ram_rdata;

  assign accept = bus.req_valid & (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    go_resp = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (LATENCY > 1) begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = RESP;
            go_resp = 1'b1;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_ONE) begin
          state_d = RESP;
          go_resp = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      rdata_live_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (go_resp) rdata_live_q <= ~acc_write;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && !rst) begin
      write_q <= bus.req_write;
      idx_q   <= bus.req_addr[DEPTH_LOG2-1:0];
      wdata_q <= bus.req_wdata;
    end
  end

  // With LATENCY==1 the access happens on the accept edge itself, before the
  // latch holds anything, so IDLE steers the live request into the RAM.
  assign acc_write = (state_q == IDLE) ? bus.req_write                   : write_q;
  assign acc_idx   = (state_q == IDLE) ? bus.req_addr[DEPTH_LOG2-1:0]    : idx_q;
  assign acc_wdata = (state_q == IDLE) ? bus.req_wdata                   : wdata_q;

  // Reset wins: an aborted store never reaches the array.
  assign mem_en = go_resp & ~rst;

  sp_sync_ram #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2),
    .INIT_FILE  (INIT_FILE)
  ) u_ram (
    .clk   (clk),
    .en    (mem_en),
    .we    (acc_write),
    .addr  (acc_idx),
    .wdata (acc_wdata),
    .rdata (ram_rdata)
  );

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.stall      = (state_q == WAIT) | ((state_q == IDLE) & bus.req_valid);
  assign bus.resp_rdata = rdata_live_q ? ram_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
  import wisc_mem_pkg::*;

  localparam int DW  = 16;
  localparam int AW  = 16;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder_if #(.DATA_W(DW), .ADDR_W(AW)) bus  ();
  dmem_responder_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();

  dmem_responder #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH_LOG2(12), .LATENCY(LAT), .INIT_FILE("")
  ) dut (.clk(clk), .rst(rst), .bus(bus));

  dmem_responder #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH_LOG2(12), .LATENCY(1), .INIT_FILE("")
  ) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] exp_q [$];
  int            acc_q [$];
  int            acc_hist [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: records accepts, pops the scoreboard on every response.
  always @(negedge clk) begin : mon
    logic [DW-1:0] e;
    int c;
    if (rst) acc_q.delete();
    else if (bus.req_valid && bus.req_ready) begin
      acc_q.push_back(cyc);
      acc_hist.push_back(cyc);
    end
    if (bus.resp_valid) begin
      if (exp_q.size() == 0 || acc_q.size() == 0) begin
        chk("unexpected_resp", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        c = acc_q.pop_front();
        chk("resp_rdata", 32'(bus.resp_rdata), 32'(e));
        chk("resp_latency", 32'(cyc - c), 32'(LAT));
        chk("ready_in_resp", 32'(bus.req_ready), 32'd0);
        chk("stall_in_resp", 32'(bus.stall), 32'd0);
      end
    end
  end

  // Issue one request; wait for accept; optionally drop req_valid afterwards.
  task automatic do_req(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [DW-1:0] e, input bit push, input bit drop);
    int n = 0;
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    if (push) exp_q.push_back(e);
    @(negedge clk);
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) chk("accept_timeout", 32'd0, 32'd1);
    else                chk("stall_at_accept", 32'(bus.stall), 32'd1);
    @(posedge clk); #1;
    if (drop) bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int base;
    bus.req_valid  = 1'b0; bus.req_write  = 1'b0; bus.req_addr  = '0; bus.req_wdata  = '0;
    bus1.req_valid = 1'b0; bus1.req_write = 1'b0; bus1.req_addr = '0; bus1.req_wdata = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_rdata", 32'(bus.resp_rdata), 32'd0);
    chk("rst_stall", 32'(bus.stall), 32'd0);
    @(posedge clk); #1;

    // Setup: place 0xBEEF at 0x0010 and 0x0000 at 0x0030
    do_req(1'b1, 16'h0010, 16'hBEEF, 16'h0000, 1'b1, 1'b1);
    drain();
    do_req(1'b1, 16'h0030, 16'h0000, 16'h0000, 1'b1, 1'b1);
    drain();

    // 1. Load with cycle-accurate timing (accept cycle = 0)
    do_req(1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b1, 1'b1);
    for (int i = 1; i < LAT; i++) begin
      @(negedge clk);
      chk("t1_stall_wait", 32'(bus.stall), 32'd1);
      chk("t1_no_resp_early", 32'(bus.resp_valid), 32'd0);
    end
    @(negedge clk);
    chk("t1_resp_valid", 32'(bus.resp_valid), 32'd1);
    chk("t1_rdata", 32'(bus.resp_rdata), 32'hBEEF);
    @(negedge clk);
    chk("t1_pulse_one_cycle", 32'(bus.resp_valid), 32'd0);
    chk("t1_rdata_hold", 32'(bus.resp_rdata), 32'hBEEF);
    @(posedge clk); #1;
    drain();

    // 2. Store then load
    do_req(1'b1, 16'h0020, 16'h1234, 16'h0000, 1'b1, 1'b1);
    do_req(1'b0, 16'h0020, 16'h0000, 16'h1234, 1'b1, 1'b1);
    drain();

    // 3. Address aliasing wraps on the low 12 bits
    do_req(1'b1, 16'hF005, 16'hA5A5, 16'h0000, 1'b1, 1'b1);
    do_req(1'b0, 16'h0005, 16'h0000, 16'hA5A5, 1'b1, 1'b1);
    do_req(1'b1, 16'h0FFF, 16'h0F0F, 16'h0000, 1'b1, 1'b1);
    do_req(1'b0, 16'hFFFF, 16'h0000, 16'h0F0F, 1'b1, 1'b1);
    drain();

    // 4. Busy: req_valid held high across three distinct requests
    base = acc_hist.size();
    do_req(1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b1, 1'b0);
    @(negedge clk);
    chk("t4_ready_low_wait", 32'(bus.req_ready), 32'd0);
    @(posedge clk); #1;
    do_req(1'b0, 16'h0020, 16'h0000, 16'h1234, 1'b1, 1'b0);
    do_req(1'b0, 16'h0005, 16'h0000, 16'hA5A5, 1'b1, 1'b1);
    drain();
    chk("t4_accept_count", 32'(acc_hist.size() - base), 32'd3);
    if (acc_hist.size() - base == 3) begin
      for (int i = 1; i < 3; i++)
        chk("t4_accept_spacing", 32'(acc_hist[base+i] - acc_hist[base+i-1]), 32'(LAT + 1));
    end

    // 5. Abort: store accepted at cycle 0, reset in cycle 2
    do_req(1'b1, 16'h0030, 16'h5555, 16'h0000, 1'b0, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < LAT + 2; i++) begin
      @(negedge clk);
      chk("t5_no_resp", 32'(bus.resp_valid), 32'd0);
    end
    @(posedge clk); #1;
    do_req(1'b0, 16'h0030, 16'h0000, 16'h0000, 1'b1, 1'b1);
    drain();

    // 6. LATENCY=1 instance
    bus1.req_valid = 1'b1; bus1.req_write = 1'b1;
    bus1.req_addr  = 16'h0005; bus1.req_wdata = 16'h7777;
    @(negedge clk);
    chk("t6_ready", 32'(bus1.req_ready), 32'd1);
    @(posedge clk); #1;
    bus1.req_valid = 1'b0;
    @(negedge clk);
    chk("t6_st_resp_valid", 32'(bus1.resp_valid), 32'd1);
    chk("t6_st_rdata", 32'(bus1.resp_rdata), 32'd0);
    @(posedge clk); #1;
    bus1.req_valid = 1'b1; bus1.req_write = 1'b0; bus1.req_addr = 16'h1005;
    @(negedge clk);
    chk("t6_ld_ready", 32'(bus1.req_ready), 32'd1);
    @(posedge clk); #1;
    bus1.req_valid = 1'b0;
    @(negedge clk);
    chk("t6_ld_resp_valid", 32'(bus1.resp_valid), 32'd1);
    chk("t6_ld_rdata", 32'(bus1.resp_rdata), 32'h7777);
    chk("t6_no_wait_stall", 32'(bus1.stall), 32'd0);
    @(negedge clk);
    chk("t6_pulse_one_cycle", 32'(bus1.resp_valid), 32'd0);
    chk("t6_rdata_hold", 32'(bus1.resp_rdata), 32'h7777);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
